// File: rtl/grf_wb_pkg.sv
// Shared constants and types for the grf_wb register file.
// The GRF_WB_BYPASS_EN macro enables write-through bypass on the read ports.
package grf_wb_pkg;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_RA   = 5'd31;

endpackage

// File: rtl/grf_wb_if.sv
// Writeback-side write port and decode-side read ports of the register file.
// The GRF_WB_BYPASS_EN macro changes only how rd1/rd2 are driven.
interface grf_wb_if;
    import grf_wb_pkg::*;

    logic        we_W;
    reg_addr_t   addr_W;
    word_t       wd_W;
    logic [31:0] pc_W;
    reg_addr_t   ra1;
    reg_addr_t   ra2;
    word_t       rd1;
    word_t       rd2;

    // Pipeline side: drives writeback and read addresses, consumes read data.
    modport master (
        output we_W, addr_W, wd_W, pc_W, ra1, ra2,
        input  rd1, rd2
    );

    // Register file side.
    modport slave (
        input  we_W, addr_W, wd_W, pc_W, ra1, ra2,
        output rd1, rd2
    );

endinterface

// File: rtl/grf_trace.sv
// Write-trace record and saturating retired-write counter for grf_wb.
// Behaviour is the same whether or not GRF_WB_BYPASS_EN is defined.
module grf_trace
    import grf_wb_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             real_we,
    input  logic [31:0]      pc,
    input  reg_addr_t        addr,
    input  word_t            data,
    output logic             trace_v,
    output logic [31:0]      trace_pc,
    output reg_addr_t        trace_addr,
    output word_t            trace_data,
    output logic [CNT_W-1:0] wr_count
);

    // Capture each retired write; payload holds when no write retires.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            trace_v    <= 1'b0;
            trace_pc   <= '0;
            trace_addr <= '0;
            trace_data <= '0;
            wr_count   <= '0;
        end else begin
            trace_v <= real_we;
            if (real_we) begin
                trace_pc   <= pc;
                trace_addr <= addr;
                trace_data <= data;
            end
            // Stop at all-ones so the count never wraps back to a small value.
            if (real_we && (wr_count != '1)) begin
                wr_count <= wr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/grf_wb.sv
// 32x32 general register file: writeback-stage sink with two combinational
// read ports, a write trace and a retired-write counter.
// Define GRF_WB_BYPASS_EN for same-cycle write-through on rd1/rd2; without it
// a read of the register being written returns the old contents.
module grf_wb
    import grf_wb_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    grf_wb_if.slave          bus,
    output logic             trace_v,
    output logic [31:0]      trace_pc,
    output reg_addr_t        trace_addr,
    output word_t            trace_data,
    output logic [CNT_W-1:0] wr_count
);

    word_t regs [NREG];
    logic  real_we;
    word_t rd1_q;
    word_t rd2_q;

    // A write only counts when enabled and aimed away from $0; an unknown
    // enable evaluates false and so behaves as no write.
    assign real_we = (bus.we_W == 1'b1) && (bus.addr_W != REG_ZERO);

    // Register array update; $0 is never written so it stays zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the whole array is reset, so it maps to flops rather than a RAM macro.
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (real_we) begin
            regs[bus.addr_W] <= bus.wd_W;
        end
    end

    // Combinational read ports, with optional write-through bypass.
    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        rd1_q = regs[bus.ra1];
        rd2_q = regs[bus.ra2];
`ifdef GRF_WB_BYPASS_EN
        if (real_we && (bus.ra1 == bus.addr_W)) rd1_q = bus.wd_W;
        if (real_we && (bus.ra2 == bus.addr_W)) rd2_q = bus.wd_W;
`endif
        if (bus.ra1 == REG_ZERO) rd1_q = '0;
        if (bus.ra2 == REG_ZERO) rd2_q = '0;
    end

    assign bus.rd1 = rd1_q;
    assign bus.rd2 = rd2_q;

    grf_trace #(
        .CNT_W (CNT_W)
    ) u_trace (
        .clk        (clk),
        .reset      (reset),
        .real_we    (real_we),
        .pc         (bus.pc_W),
        .addr       (bus.addr_W),
        .data       (bus.wd_W),
        .trace_v    (trace_v),
        .trace_pc   (trace_pc),
        .trace_addr (trace_addr),
        .trace_data (trace_data),
        .wr_count   (wr_count)
    );

endmodule

// File: tb/tb_grf_wb.sv
// Directed self-checking bench for grf_wb: a default-width instance for the
// functional checks and a CNT_W=4 instance for counter saturation.
module tb_grf_wb;
    import grf_wb_pkg::*;

    logic clk;
    logic reset;
    logic reset_sat;

    int checks   = 0;
    int failures = 0;

    grf_wb_if bus ();
    grf_wb_if bus_sat ();

    logic             trace_v;
    logic [31:0]      trace_pc;
    reg_addr_t        trace_addr;
    word_t            trace_data;
    logic [31:0]      wr_count;

    logic             sat_trace_v;
    logic [31:0]      sat_trace_pc;
    reg_addr_t        sat_trace_addr;
    word_t            sat_trace_data;
    logic [3:0]       sat_wr_count;

    grf_wb dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .trace_v    (trace_v),
        .trace_pc   (trace_pc),
        .trace_addr (trace_addr),
        .trace_data (trace_data),
        .wr_count   (wr_count)
    );

    grf_wb #(.CNT_W(4)) dut_sat (
        .clk        (clk),
        .reset      (reset_sat),
        .bus        (bus_sat.slave),
        .trace_v    (sat_trace_v),
        .trace_pc   (sat_trace_pc),
        .trace_addr (sat_trace_addr),
        .trace_data (sat_trace_data),
        .wr_count   (sat_wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge so registered outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; reset_sat = 1'b0;
        bus.we_W = 1'b0; bus.addr_W = '0; bus.wd_W = '0; bus.pc_W = '0;
        bus.ra1 = '0; bus.ra2 = '0;
        bus_sat.we_W = 1'b0; bus_sat.addr_W = '0; bus_sat.wd_W = '0; bus_sat.pc_W = '0;
        bus_sat.ra1 = '0; bus_sat.ra2 = '0;

        // Reset then read.
        tick(); tick();
        reset = 1'b1; reset_sat = 1'b1;
        bus.ra1 = 5'd5; bus.ra2 = REG_RA;
        #1;
        check("rst_rd1", bus.rd1, 64'h0);
        check("rst_rd2", bus.rd2, 64'h0);
        check("rst_cnt", wr_count, 64'h0);
        check("rst_tv", trace_v, 64'h0);

        // Basic write to r8.
        bus.we_W = 1'b1; bus.addr_W = 5'd8; bus.wd_W = 32'h1234_5678; bus.pc_W = 32'h0000_3000;
        tick();
        bus.we_W = 1'b0; bus.ra1 = 5'd8;
        #1;
        check("wr_rd1", bus.rd1, 64'h1234_5678);
        check("wr_tv", trace_v, 64'h1);
        check("wr_tpc", trace_pc, 64'h3000);
        check("wr_taddr", trace_addr, 64'h8);
        check("wr_tdata", trace_data, 64'h1234_5678);
        check("wr_cnt", wr_count, 64'h1);

        // $0 write is dropped; trace payload holds.
        bus.we_W = 1'b1; bus.addr_W = REG_ZERO; bus.wd_W = 32'hFFFF_FFFF; bus.pc_W = 32'h0000_3004;
        bus.ra1 = REG_ZERO;
        #1;
        check("z_rd1_same", bus.rd1, 64'h0);
        tick();
        bus.we_W = 1'b0;
        #1;
        check("z_rd1", bus.rd1, 64'h0);
        check("z_tv", trace_v, 64'h0);
        check("z_cnt", wr_count, 64'h1);
        check("z_tpc_hold", trace_pc, 64'h3000);
        check("z_tdata_hold", trace_data, 64'h1234_5678);

        // Same-cycle read/write of r9.
        bus.we_W = 1'b1; bus.addr_W = 5'd9; bus.wd_W = 32'hA; bus.pc_W = 32'h0000_3008;
        tick();
        bus.wd_W = 32'hB; bus.pc_W = 32'h0000_300C;
        bus.ra1 = 5'd9; bus.ra2 = 5'd9;
        #1;
`ifdef GRF_WB_BYPASS_EN
        check("rw_rd1_same", bus.rd1, 64'hB);
        check("rw_rd2_same", bus.rd2, 64'hB);
`else
        check("rw_rd1_same", bus.rd1, 64'hA);
        check("rw_rd2_same", bus.rd2, 64'hA);
`endif
        tick();
        bus.we_W = 1'b0;
        #1;
        check("rw_rd1_next", bus.rd1, 64'hB);
        check("rw_rd2_next", bus.rd2, 64'hB);
        check("rw_cnt", wr_count, 64'h3);
        check("rw_taddr", trace_addr, 64'h9);
        bus.ra1 = 5'd8; bus.ra2 = 5'd8;
        #1;
        check("r8_kept_p1", bus.rd1, 64'h1234_5678);
        check("r8_kept_p2", bus.rd2, 64'h1234_5678);

        // Reset mid-stream wins over a simultaneous write.
        bus.we_W = 1'b1; bus.addr_W = REG_RA; bus.wd_W = 32'h3004; bus.pc_W = 32'h0000_3010;
        tick();
        bus.ra1 = REG_RA; bus.ra2 = 5'd4;
        bus.addr_W = 5'd4; bus.wd_W = 32'h7; bus.pc_W = 32'h0000_3014;
        reset = 1'b0;
        #1;
        check("pre_rst_r31", bus.rd1, 64'h3004);
        check("pre_rst_cnt", wr_count, 64'h4);
        tick();
        reset = 1'b1; bus.we_W = 1'b0;
        #1;
        check("mrst_r31", bus.rd1, 64'h0);
        check("mrst_r4", bus.rd2, 64'h0);
        check("mrst_cnt", wr_count, 64'h0);
        check("mrst_tv", trace_v, 64'h0);
        check("mrst_tpc", trace_pc, 64'h0);

        // Counter saturation on the 4-bit instance: 20 real writes.
        for (int i = 0; i < 20; i++) begin
            bus_sat.we_W = 1'b1;
            bus_sat.addr_W = reg_addr_t'((i % 31) + 1);
            bus_sat.wd_W = word_t'(i);
            bus_sat.pc_W = 32'h0000_4000 + 32'(i * 4);
            tick();
            if (i == 13) check("sat_cnt_14", sat_wr_count, 64'hE);
            if (i == 14) check("sat_cnt_15", sat_wr_count, 64'hF);
        end
        bus_sat.we_W = 1'b0;
        tick();
        check("sat_cnt_20", sat_wr_count, 64'hF);
        check("sat_tdata", sat_trace_data, 64'd19);
        check("sat_tv_drop", sat_trace_v, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/grf_wb.md
Name: grf_wb

Overview:
- 32x32 general register file; the write-side sink for the writeback stage of the five-stage MIPS pipeline.
- Accepts the writeback triple (write data, destination address, write enable) plus the instruction PC.
- Serves two combinational read ports to the decode stage.
- Keeps a registered write-trace record and a retired-write counter for the bench and commit logging.

Parameters:
- DW, 32, data width of each register.
- AW, 5, register address width.
- NREG, 32, number of registers; must equal 2**AW.
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset).
- we_W  input  1  write enable from writeback stage.
- addr_W  input  AW  destination register number.
- wd_W  input  DW  write data.
- pc_W  input  32  PC of the instruction in writeback.
- ra1  input  AW  read address, port 1 (rs).
- ra2  input  AW  read address, port 2 (rt).
- rd1  output  DW  read data, port 1.
- rd2  output  DW  read data, port 2.
- trace_v  output  1  registered: a real write retired last cycle.
- trace_pc  output  32  PC of that write.
- trace_addr  output  AW  register written.
- trace_data  output  DW  value written.
- wr_count  output  CNT_W  number of real writes retired since reset.

Behaviour:
- Reset (reset==0 at a rising edge):
  - all NREG registers <= 0;
  - trace_v, trace_pc, trace_addr, trace_data <= 0;
  - wr_count <= 0.
  - Reset wins over a simultaneous write, including when asserted mid-stream.
- Real write is defined as we_W==1 && addr_W!=0.
- Write:
  - On a rising edge with reset==1 and a real write, reg[addr_W] <= wd_W.
  - Latency is 1 cycle: the new value is visible on rd1/rd2 from the next cycle without bypass.
- Register 0:
  - always reads 0;
  - writes to it are dropped and produce no trace and no count.
- Reads:
  - Purely combinational from the current array: rd1 = reg[ra1], rd2 = reg[ra2].
  - The ra==0 case returns 0 regardless of bypass.
- Trace:
  - Each cycle, trace_v <= real write.
  - When it is a real write, trace_pc/addr/data <= pc_W/addr_W/wd_W.
  - Otherwise trace_pc/addr/data hold their previous values; only trace_v drops.
- Counter:
  - wr_count increments by 1 on each real write.
  - Saturates at all-ones and does not wrap.
- Simultaneous events:
  - Two ports reading the same register return identical data.
  - A read of the register being written this cycle returns the old value unless the optional feature below is compiled in.
- X-handling: we_W==X is treated as no write.

Optional Feature:
- Macro: GRF_WB_BYPASS_EN.
- Defined: write-through bypass.
  - If the cycle has a real write and ra1==addr_W, then rd1 = wd_W in the same cycle; likewise rd2.
  - Lets the decode stage drop the W->D forwarding path.
- Undefined:
  - Reads return array contents only (old value during a same-cycle write).
  - Pipeline hazard logic must forward W->D externally.
- Trace and counter behaviour is identical in both builds.

Decomposition:
- Shared package holds:
  - DW, AW, NREG constants;
  - REG_ZERO (5'd0) and REG_RA (5'd31) constants;
  - the reg_addr_t and word_t typedefs.
- One sub-module is natural: grf_trace, holding the trace registers and the saturating counter, fed by the real-write qualifier.
- Array and read muxes stay in grf_wb.

Test Plan:
- Reset then read: hold reset=0 for 2 cycles, release; ra1=5, ra2=31 -> rd1=0, rd2=0, wr_count=0, trace_v=0.
- Basic write: we_W=1, addr_W=8, wd_W=32'h1234_5678, pc_W=32'h0000_3000 for one cycle.
  - Next cycle: ra1=8 -> rd1=32'h1234_5678.
  - trace_v=1, trace_pc=32'h3000, trace_addr=8, trace_data=32'h1234_5678, wr_count=1.
- $0 write: we_W=1, addr_W=0, wd_W=32'hFFFF_FFFF -> rd1(ra1=0)=0, trace_v=0, wr_count unchanged.
- Same-cycle read/write: reg9=32'hA; drive we_W=1, addr_W=9, wd_W=32'hB with ra1=ra2=9.
  - With GRF_WB_BYPASS_EN: rd1=rd2=32'hB this cycle.
  - Without it: rd1=rd2=32'hA this cycle.
  - Both builds: 32'hB next cycle.
- Reset mid-stream: write reg31=32'h3004, then assert reset=0 in the same cycle as a write to reg4=7.
  - Next cycle: reg31=0, reg4=0, wr_count=0, trace_v=0.
- Counter saturation: build with CNT_W=4 and issue 20 real writes -> wr_count stops at 4'hF and does not wrap to 0.
